ap_core_param: RTL
==================

# ap_core_param

Parametrised associative-processing core: CELL_QUANT rows, each holding three WORD_SIZE-bit columns (A, B, C) plus a per-row carry/borrow bit. It replaces the fixed single-function AP core. It adds a command set (ADD, SUB, AND, OR, XOR), bit-serial compare/write passes over truth tables, a readable carry column and an error flag for reserved commands. Host-side memory access uses the same addr/data/sel_col/write_en/read_en style as the existing AP wrappers.

## Interface
- WORD_SIZE, 8, bits per column word
- CELL_QUANT, 512, number of rows; ADDR_W = clogb2(CELL_QUANT) (10 for 512)
- CLK100MHZ  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ap_mode  in  1  level; high in IDLE starts the operation selected by cmd
- cmd  in  3  0 ADD (C=A+B), 1 SUB (C=A-B), 2 AND, 3 OR, 4 XOR, 5-7 reserved
- sel_col  in  2  0 A, 1 B, 2 C, 3 carry column (read-only, LSB of word)
- write_en  in  1  write data_in to row addr_in, column sel_col
- read_en  in  1  read row addr_in, column sel_col into data_out
- addr_in  in  ADDR_W  row address
- data_in  in  WORD_SIZE  write data
- data_out  out  WORD_SIZE  registered read data
- busy  out  1  high while an operation runs (INIT..COMMIT)
- ap_state_irq  out  1  completion flag, level
- cmd_err  out  1  last started cmd was reserved

## Operation
- FSM states: IDLE, INIT, COMPARE, WRITE, COMMIT, DONE. Bit index i runs 0..WORD_SIZE-1. Pass index p runs 0..P-1. P=8 for ADD/SUB (all combos of carry,a,b); P=4 for logic ops (combos of a,b).
- IDLE: ap_mode=1 latches cmd and moves to INIT. A reserved cmd goes to DONE with cmd_err=1, and C is untouched.
- INIT (1 cycle): clear carry[] and carry_next[] for all rows.
- COMPARE: tags[r] = (A[r][i],B[r][i]) matches the pass key; for ADD/SUB, carry[r] must match as well.
- WRITE: for each tagged row, C[r][i] <= f(key) and carry_next[r] <= g(key). After the last pass go to COMMIT, otherwise return to COMPARE with p+1.
- COMMIT: carry <= carry_next. If i = WORD_SIZE-1, go to DONE; otherwise i+1, p=0, COMPARE.
- ADD: f = a^b^c, g = maj(a,b,c). SUB: f = a^b^bw, g = (~a&b)|(~a&bw)|(b&bw). Results are mod 2^WORD_SIZE. The final carry/borrow remains in the carry column.
- DONE: ap_state_irq=1 and busy=0. The FSM waits for ap_mode=0, then returns to IDLE. ap_state_irq clears on that transition.
- Writes: accepted only in IDLE or DONE, and only when addr_in < CELL_QUANT and sel_col ≠ 3. Otherwise they are dropped silently.
- Reads: serviced in every state and return the current contents. Out-of-range addresses read 0. sel_col=3 returns {0…,carry[r]}.
- Read and write to the same location in the same cycle: data_out returns the old value (read-first).
- write_en together with ap_mode=1 in IDLE: the write lands, and the operation sees the new data because the first COMPARE follows INIT.
- cmd_err clears when the next operation starts.
- Column storage is not reset. carry[] is cleared on reset.

## Timing
- Reset values: data_out=0, busy=0, ap_state_irq=0, cmd_err=0, state IDLE. Reset mid-operation aborts immediately, and C may be partially written.
- Read latency is 1 cycle: data_out is valid on the edge after the read_en sample. data_out holds its value when read_en=0.
- ap_mode is sampled high in IDLE at edge T0, and busy rises at T0.
- ap_state_irq rises and busy falls at T0+L, where L = 1 + WORD_SIZE·(2P+1).
  - ADD/SUB, WORD_SIZE=8: L=137.
  - Logic ops: L=73.
  - Reserved cmd: L=1, with busy never asserted.
- ap_mode=0 sampled in DONE at edge Tn gives ap_state_irq=0 at Tn. A new start is possible at Tn+1 at the earliest.
- ap_mode held high through DONE does not retrigger.

## Test plan
- Write A[1]=1, B[1]=1, cmd=ADD, ap_mode=1 -> ap_state_irq at T0+137; read C[1] -> 2, carry[1] -> 0.
- A[5]=200, B[5]=100, A[511]=255, B[511]=1, ADD -> C[5]=44 with carry 1; C[511]=0 with carry 1; all other written rows correct.
- SUB with A[7]=5, B[7]=9 -> C[7]=252, borrow 1. XOR with A[2]=0xF0, B[2]=0x3C -> C[2]=0xCC, irq at T0+73.
- Write to C[1] while busy -> ignored (C[1] equals the op result). Write with addr_in=600 -> ignored, and reading addr 600 returns 0. cmd=6 -> irq at T0+1, cmd_err=1, C unchanged.
- Assert rst at T0+50 of an ADD -> busy, ap_state_irq, cmd_err and data_out all 0 asynchronously. After release, re-run ADD on rewritten operands -> correct result at T0'+137.
- Hold ap_mode high after DONE -> no restart. Drop ap_mode, raise it again with cmd=OR, A=0x0F, B=0xF0 -> C=0xFF.

Source files
------------

// File: rtl/ap_core_param.sv
// Parametrised associative-processing core: bit-serial ADD/SUB/AND/OR/XOR over
// CELL_QUANT rows of A/B/C columns using truth-table compare/write passes.
module ap_core_param #(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned CELL_QUANT = 512,
  parameter int unsigned ADDR_W     = $clog2(CELL_QUANT + 1)
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst,
  input  logic                 ap_mode,
  input  logic [2:0]           cmd,
  input  logic [1:0]           sel_col,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic [ADDR_W-1:0]    addr_in,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 busy,
  output logic                 ap_state_irq,
  output logic                 cmd_err
);

  localparam int unsigned ROW_W = (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1;
  localparam int unsigned BIT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  localparam logic [2:0] CMD_ADD = 3'd0;
  localparam logic [2:0] CMD_SUB = 3'd1;
  localparam logic [2:0] CMD_AND = 3'd2;
  localparam logic [2:0] CMD_OR  = 3'd3;
  localparam logic [2:0] CMD_XOR = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_COMPARE, S_WRITE, S_COMMIT, S_DONE
  } state_t;

  state_t                 state_q;
  logic [2:0]             cmd_q;
  logic [BIT_W-1:0]       bit_q;
  logic [2:0]             pass_q;
  logic                   busy_q;
  logic                   irq_q;
  logic                   err_q;
  logic [WORD_SIZE-1:0]   data_q;

  logic [CELL_QUANT-1:0]  carry_q;
  logic [CELL_QUANT-1:0]  carry_nx_q;
  logic [CELL_QUANT-1:0]  tags_q;

  logic [WORD_SIZE-1:0]   mem_a [CELL_QUANT];
  logic [WORD_SIZE-1:0]   mem_b [CELL_QUANT];
  logic [WORD_SIZE-1:0]   mem_c [CELL_QUANT];

  logic                   in_range_c;
  logic [ROW_W-1:0]       row_c;
  logic                   host_wr_c;
  logic                   arith_c;
  logic                   last_pass_c;
  logic                   ka_c, kb_c, kc_c;
  logic                   f_c, g_c;

  assign data_out     = data_q;
  assign busy         = busy_q;
  assign ap_state_irq = irq_q;
  assign cmd_err      = err_q;

  // Host address decode and write qualification (only while no op is running)
  always_comb begin
    in_range_c = 32'(addr_in) < CELL_QUANT;
    row_c      = addr_in[ROW_W-1:0];
    host_wr_c  = write_en && in_range_c && (sel_col != 2'd3) &&
                 ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  // Pass key decode and truth-table outputs f (result bit) / g (carry/borrow)
  always_comb begin
    arith_c     = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB);
    last_pass_c = arith_c ? (pass_q == 3'd7) : (pass_q == 3'd3);
    kc_c        = pass_q[2];
    ka_c        = pass_q[1];
    kb_c        = pass_q[0];
    f_c         = 1'b0;
    g_c         = 1'b0;
    case (cmd_q)
      CMD_ADD: begin
        f_c = ka_c ^ kb_c ^ kc_c;
        g_c = (ka_c & kb_c) | (ka_c & kc_c) | (kb_c & kc_c);
      end
      CMD_SUB: begin
        f_c = ka_c ^ kb_c ^ kc_c;
        g_c = (~ka_c & kb_c) | (~ka_c & kc_c) | (kb_c & kc_c);
      end
      CMD_AND: f_c = ka_c & kb_c;
      CMD_OR:  f_c = ka_c | kb_c;
      CMD_XOR: f_c = ka_c ^ kb_c;
      default: f_c = 1'b0;
    endcase
  end

  // Control FSM: sequences INIT, per-bit compare/write passes and commit
  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      bit_q   <= '0;
      pass_q  <= '0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ap_mode) begin
            cmd_q   <= cmd;
            bit_q   <= '0;
            pass_q  <= '0;
            err_q   <= (cmd > CMD_XOR);
            busy_q  <= (cmd <= CMD_XOR);
            state_q <= S_INIT;
          end
        end
        S_INIT: begin
          // A reserved command skips straight to DONE without touching storage
          if (err_q) begin
            irq_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_COMPARE;
          end
        end
        S_COMPARE: state_q <= S_WRITE;
        S_WRITE: begin
          if (last_pass_c) begin
            state_q <= S_COMMIT;
          end else begin
            pass_q  <= pass_q + 3'd1;
            state_q <= S_COMPARE;
          end
        end
        S_COMMIT: begin
          if (bit_q == BIT_W'(WORD_SIZE - 1)) begin
            busy_q  <= 1'b0;
            irq_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            bit_q   <= bit_q + BIT_W'(1);
            pass_q  <= '0;
            state_q <= S_COMPARE;
          end
        end
        S_DONE: begin
          if (!ap_mode) begin
            irq_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Per-row tag match, carry_next update and carry commit
  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      carry_q    <= '0;
      carry_nx_q <= '0;
      tags_q     <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (!err_q) begin
            carry_q    <= '0;
            carry_nx_q <= '0;
          end
        end
        S_COMPARE: begin
          for (int unsigned r = 0; r < CELL_QUANT; r++) begin
            tags_q[ROW_W'(r)] <= (mem_a[ROW_W'(r)][bit_q] == ka_c) &&
                                 (mem_b[ROW_W'(r)][bit_q] == kb_c) &&
                                 (!arith_c || (carry_q[ROW_W'(r)] == kc_c));
          end
        end
        S_WRITE: begin
          for (int unsigned r = 0; r < CELL_QUANT; r++) begin
            if (tags_q[ROW_W'(r)]) carry_nx_q[ROW_W'(r)] <= g_c;
          end
        end
        S_COMMIT: carry_q <= carry_nx_q;
        default: ;
      endcase
    end
  end

  // Column storage (not reset): host writes and tagged result-bit writes
  always_ff @(posedge CLK100MHZ) begin
    if (host_wr_c) begin
      case (sel_col)
        2'd0:    mem_a[row_c] <= data_in;
        2'd1:    mem_b[row_c] <= data_in;
        2'd2:    mem_c[row_c] <= data_in;
        default: ;
      endcase
    end
    if (state_q == S_WRITE) begin
      for (int unsigned r = 0; r < CELL_QUANT; r++) begin
        if (tags_q[ROW_W'(r)]) mem_c[ROW_W'(r)][bit_q] <= f_c;
      end
    end
  end

  // Registered read port, read-first against a same-cycle write
  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (read_en) begin
      if (!in_range_c) begin
        data_q <= '0;
      end else begin
        case (sel_col)
          2'd0:    data_q <= mem_a[row_c];
          2'd1:    data_q <= mem_b[row_c];
          2'd2:    data_q <= mem_c[row_c];
          default: data_q <= WORD_SIZE'(carry_q[row_c]);
        endcase
      end
    end
  end

endmodule
